// File: rtl/fmc_core_bus_arbiter_pkg.sv
// rtl/fmc_core_bus_arbiter_pkg.sv - shared types and constants for the core bus arbiter
// Purpose: FSM state encoding, read-latency counter width, index-width helper.
// Ports:   none (package).
package fmc_core_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Wide enough for RD_LAT-1 with RD_LAT up to 15.
   localparam int CNT_W = 4;

   // Width of a requester index; a single requester still needs one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational round-robin priority picker
// Purpose: selects the first set request bit at or above ptr, wrapping to 0.
// Ports:
//   req    in   NUM_REQ   request vector
//   ptr    in   IDX_W     highest-priority index this round
//   grant  out  NUM_REQ   one-hot winner (all zero when req is zero)
//   index  out  IDX_W     binary winner index
module rr_priority_picker
   import fmc_core_bus_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   index
);

   localparam logic [IDX_W:0] NUM = (IDX_W+1)'(NUM_REQ);

   // rot[i] is req[(ptr+i) mod NUM_REQ]: the doubled vector makes the wrap free.
   logic [NUM_REQ-1:0] rot;
   logic [IDX_W:0]     sum;
   logic               found;

   assign rot = NUM_REQ'({req, req} >> ptr);

   always_comb begin
      found = 1'b0;
      sum   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && rot[i]) begin
            found = 1'b1;
            sum   = {1'b0, ptr} + (IDX_W+1)'(i);
         end
      end
      if (sum >= NUM) begin
         sum = sum - NUM;
      end
      index = sum[IDX_W-1:0];
      grant = found ? (NUM_REQ'(1) << index) : '0;
   end

endmodule

// File: rtl/fmc_core_bus_arbiter.sv
// rtl/fmc_core_bus_arbiter.sv - round-robin arbiter for the sys_clk core register bus
// Purpose: grants one requester at a time, latches its command, runs one write or one
//          fixed-latency read on the core bus and acks only the winner.
// Ports:
//   sys_clk, sys_rst        clock, asynchronous active-high reset
//   req_valid/we/addr/wdata per-requester command (addr/wdata packed, requester i at i*W)
//   req_ack                 one-cycle completion pulse to the winner
//   req_rdata               read data, valid in the ack cycle of a read, then held
//   core_addr/wdata         core bus command, held between transactions
//   core_wren/rden          one-cycle core strobes
//   core_rdata              core read data, RD_LAT cycles after core_rden
//   busy                    transaction in flight
module fmc_core_bus_arbiter
   import fmc_core_bus_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = 22,
   parameter int DATA_W  = 32,
   parameter int RD_LAT  = 2
) (
   input  logic                      sys_clk,
   input  logic                      sys_rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_we,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        req_ack,
   output logic [DATA_W-1:0]         req_rdata,
   output logic [ADDR_W-1:0]         core_addr,
   output logic                      core_wren,
   output logic                      core_rden,
   output logic [DATA_W-1:0]         core_wdata,
   input  logic [DATA_W-1:0]         core_rdata,
   output logic                      busy
);

   localparam int                IDX_W    = idx_width(NUM_REQ);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_REQ - 1);
   localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
   localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(RD_LAT - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

   state_t               state, state_nx;
   logic [CNT_W-1:0]     cnt, cnt_nx;
   logic                 we_q;
   logic [NUM_REQ-1:0]   grant_q;
   logic [IDX_W-1:0]     ptr;
   logic [DATA_W-1:0]    rdata_q;
   logic [NUM_REQ-1:0]   pick_grant;
   logic [IDX_W-1:0]     pick_index;
   logic                 idle_take;

   rr_priority_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .req   (req_valid),
      .ptr   (ptr),
      .grant (pick_grant),
      .index (pick_index)
   );

   assign idle_take = (state == ST_IDLE) && (|req_valid);

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         ST_IDLE: begin
            if (|req_valid) begin
               state_nx = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (we_q) begin
               state_nx = ST_IDLE;
            end else begin
               cnt_nx   = CNT_LOAD;
               state_nx = (RD_LAT > 1) ? ST_WAIT : ST_DONE;
            end
         end
         ST_WAIT: begin
            // Leaving on cnt==1 puts DONE exactly RD_LAT cycles after the rden cycle.
            cnt_nx = cnt - CNT_ONE;
            if (cnt == CNT_ONE) begin
               state_nx = ST_DONE;
            end
         end
         ST_DONE: begin
            state_nx = ST_IDLE;
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   // Strobes and ack decode straight from state so reset drops them immediately.
   always_comb begin
      core_wren = (state == ST_ISSUE) && we_q;
      core_rden = (state == ST_ISSUE) && !we_q;
      req_ack   = (core_wren || (state == ST_DONE)) ? grant_q : '0;
      busy      = (state != ST_IDLE);
      // Read data must be visible in the DONE cycle itself, so bypass the holding register.
      req_rdata = (state == ST_DONE) ? core_rdata : rdata_q;
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         we_q       <= 1'b0;
         grant_q    <= '0;
         ptr        <= '0;
         core_addr  <= '0;
         core_wdata <= '0;
         rdata_q    <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (idle_take) begin
            we_q       <= req_we[pick_index];
            grant_q    <= pick_grant;
            core_addr  <= req_addr[pick_index*ADDR_W +: ADDR_W];
            core_wdata <= req_wdata[pick_index*DATA_W +: DATA_W];
            ptr        <= (pick_index == IDX_LAST) ? '0 : pick_index + IDX_ONE;
         end
         if (state == ST_DONE) begin
            rdata_q <= core_rdata;
         end
      end
   end

endmodule

// File: tb/tb_fmc_core_bus_arbiter.sv
// tb/tb_fmc_core_bus_arbiter.sv - self-checking bench for fmc_core_bus_arbiter
module tb_fmc_core_bus_arbiter;

   localparam int N    = 2;
   localparam int AW   = 22;
   localparam int DW   = 32;
   localparam int RL   = 2;
   localparam int N4   = 4;
   localparam int RL4  = 1;
   localparam int MAXC = 5;
   localparam int MAXT = N * MAXC;

   logic            sys_clk = 1'b0;
   logic            sys_rst = 1'b1;
   logic [N-1:0]    req_valid = '0;
   logic [N-1:0]    req_we = '0;
   logic [N*AW-1:0] req_addr = '0;
   logic [N*DW-1:0] req_wdata = '0;
   logic [N-1:0]    req_ack;
   logic [DW-1:0]   req_rdata;
   logic [AW-1:0]   core_addr;
   logic            core_wren, core_rden;
   logic [DW-1:0]   core_wdata;
   logic [DW-1:0]   core_rdata = '0;
   logic            busy;

   logic [N4-1:0]    f_valid = '0;
   logic [N4-1:0]    f_we = '0;
   logic [N4*AW-1:0] f_addr = '0;
   logic [N4*DW-1:0] f_wdata = '0;
   logic [N4-1:0]    f_ack;
   logic [DW-1:0]    f_rdata;
   logic [AW-1:0]    f_core_addr;
   logic             f_core_wren, f_core_rden;
   logic [DW-1:0]    f_core_wdata;
   logic [DW-1:0]    f_core_rdata = '0;
   logic             f_busy;

   int errors = 0;
   int checks = 0;
   int gcyc = 0;
   int model_ptr = 0;
   logic [DW-1:0] exp_rdata = '0;
   logic core_fixed_en = 1'b0;
   logic [DW-1:0] core_fixed = '0;

   // command tables per requester and the predicted transaction schedule
   logic          cw [N][MAXC];
   logic [AW-1:0] ca [N][MAXC];
   logic [DW-1:0] cd [N][MAXC];
   int            gap [N][MAXC];
   logic          early [N][MAXC];
   int            ncmd [N];
   int tg [MAXT];
   int tj [MAXT];
   int tt [MAXT];
   int tack [MAXT];
   int trdy [MAXT];
   int ntx;
   int obs [$];

   int pend_due [$];
   logic [DW-1:0] pend_val [$];
   logic f_rd_seen = 1'b0;
   logic [AW-1:0] f_rd_addr = '0;

   fmc_core_bus_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .req_valid(req_valid), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ack(req_ack), .req_rdata(req_rdata),
      .core_addr(core_addr), .core_wren(core_wren), .core_rden(core_rden),
      .core_wdata(core_wdata), .core_rdata(core_rdata), .busy(busy));

   fmc_core_bus_arbiter #(.NUM_REQ(N4), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL4)) dut4 (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .req_valid(f_valid), .req_we(f_we),
      .req_addr(f_addr), .req_wdata(f_wdata), .req_ack(f_ack), .req_rdata(f_rdata),
      .core_addr(f_core_addr), .core_wren(f_core_wren), .core_rden(f_core_rden),
      .core_wdata(f_core_wdata), .core_rdata(f_core_rdata), .busy(f_busy));

   always #5 sys_clk = ~sys_clk;

   function automatic logic [DW-1:0] core_val(input logic [AW-1:0] a);
      if (core_fixed_en) return core_fixed;
      return ({10'h0, a} * 32'h9E3779B1) ^ 32'h5A5A5A5A;
   endfunction

   // core bus models: data appears exactly RL (RL4) cycles after the rden cycle, junk otherwise
   always @(negedge sys_clk) begin
      if (core_rden === 1'b1) begin
         pend_due.push_back(gcyc + RL);
         pend_val.push_back(core_val(core_addr));
      end
      f_rd_seen = (f_core_rden === 1'b1);
      f_rd_addr = f_core_addr;
   end

   always @(posedge sys_clk) begin
      #1;
      gcyc++;
      while (pend_due.size() > 0 && pend_due[0] < gcyc) begin
         void'(pend_due.pop_front());
         void'(pend_val.pop_front());
      end
      if (pend_due.size() > 0 && pend_due[0] == gcyc) begin
         core_rdata = pend_val[0];
         void'(pend_due.pop_front());
         void'(pend_val.pop_front());
      end else begin
         core_rdata = $urandom;
      end
      f_core_rdata = f_rd_seen ? core_val(f_rd_addr) : $urandom;
   end

   task automatic clear_cmds();
      for (int i = 0; i < N; i++) begin
         ncmd[i] = 0;
         for (int j = 0; j < MAXC; j++) begin
            cw[i][j] = 1'b1; ca[i][j] = '0; cd[i][j] = '0; gap[i][j] = 0; early[i][j] = 1'b0;
         end
      end
   endtask

   // Transaction-level prediction: at each idle decision point the first ready requester
   // from the pointer wins; writes take 2 cycles, reads RL+2.
   task automatic build_sched();
      int ptr, t;
      int nxt [N];
      int ready [N];
      ptr = model_ptr; t = 0; ntx = 0;
      for (int i = 0; i < N; i++) begin nxt[i] = 0; ready[i] = gap[i][0]; end
      while (1) begin
         int g, tmin;
         g = -1; tmin = 1000000;
         for (int k = 0; k < N; k++) begin
            int i;
            i = (ptr + k) % N;
            if (nxt[i] < ncmd[i]) begin
               if (ready[i] <= t && g < 0) g = i;
               if (ready[i] < tmin) tmin = ready[i];
            end
         end
         if (tmin == 1000000) break;
         if (g < 0) begin t = tmin; continue; end
         tg[ntx] = g; tj[ntx] = nxt[g]; trdy[ntx] = ready[g]; tt[ntx] = t;
         tack[ntx] = cw[g][nxt[g]] ? t + 1 : t + 1 + RL;
         ptr = (g + 1) % N;
         t = tack[ntx] + 1;
         nxt[g]++;
         if (nxt[g] < ncmd[g]) ready[g] = tack[ntx] + 2 + gap[g][nxt[g]];
         ntx++;
      end
      model_ptr = ptr;
   endtask

   task automatic run_round(input string tag);
      int last;
      build_sched();
      last = (ntx > 0) ? tack[ntx-1] : 0;
      obs.delete();
      for (int c = 0; c <= last + 2; c++) begin
         logic [N-1:0] e_ack;
         logic e_wren, e_rden, e_busy;
         logic [AW-1:0] e_addr;
         logic [DW-1:0] e_wd;
         @(negedge sys_clk);
         e_ack = '0; e_wren = 0; e_rden = 0; e_busy = 0; e_addr = '0; e_wd = '0;
         for (int k = 0; k < ntx; k++) begin
            int g, j;
            g = tg[k]; j = tj[k];
            if (tt[k] + 1 <= c && c <= tack[k]) begin e_busy = 1; e_addr = ca[g][j]; end
            if (tack[k] == c) begin
               e_ack[g] = 1'b1;
               if (cw[g][j]) begin e_wren = 1; e_wd = cd[g][j]; end
               else exp_rdata = core_val(ca[g][j]);
            end
            if (!cw[g][j] && tt[k] + 1 == c) e_rden = 1;
         end
         checks++;
         if (req_ack !== e_ack) begin errors++;
            $display("FAIL %s ack c=%0d: got %b expected %b", tag, c, req_ack, e_ack); end
         checks++;
         if (core_wren !== e_wren || core_rden !== e_rden) begin errors++;
            $display("FAIL %s strobes c=%0d: got wren=%b rden=%b expected %b %b", tag, c, core_wren, core_rden, e_wren, e_rden); end
         checks++;
         if (busy !== e_busy) begin errors++;
            $display("FAIL %s busy c=%0d: got %b expected %b", tag, c, busy, e_busy); end
         checks++;
         if (req_rdata !== exp_rdata) begin errors++;
            $display("FAIL %s rdata c=%0d: got %h expected %h", tag, c, req_rdata, exp_rdata); end
         if (e_busy) begin
            checks++;
            if (core_addr !== e_addr) begin errors++;
               $display("FAIL %s core_addr c=%0d: got %h expected %h", tag, c, core_addr, e_addr); end
         end
         if (e_wren) begin
            checks++;
            if (core_wdata !== e_wd) begin errors++;
               $display("FAIL %s core_wdata c=%0d: got %h expected %h", tag, c, core_wdata, e_wd); end
         end
         for (int i = 0; i < N; i++) if (req_ack[i] === 1'b1) obs.push_back(i);
         // requester behaviour: valid from its ready cycle until its (predicted) ack
         for (int i = 0; i < N; i++) begin
            req_valid[i] = 1'b0;
            req_we[i] = 1'($urandom);
            req_addr[i*AW +: AW] = AW'($urandom);
            req_wdata[i*DW +: DW] = $urandom;
            for (int k = 0; k < ntx; k++) begin
               int j, stop;
               j = tj[k];
               stop = (early[i][j] && !cw[i][j]) ? tt[k] + 2 : tack[k];
               if (tg[k] == i && trdy[k] <= c && c < stop) begin
                  req_valid[i] = 1'b1; req_we[i] = cw[i][j];
                  req_addr[i*AW +: AW] = ca[i][j]; req_wdata[i*DW +: DW] = cd[i][j];
               end
            end
         end
      end
      req_valid = '0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge sys_clk);
      checks++;
      if (req_ack !== '0 || core_wren !== 1'b0 || core_rden !== 1'b0 || busy !== 1'b0) begin errors++;
         $display("FAIL reset ctl: got ack=%b wren=%b rden=%b busy=%b expected 0", req_ack, core_wren, core_rden, busy); end
      checks++;
      if (core_addr !== '0 || core_wdata !== '0 || req_rdata !== '0) begin errors++;
         $display("FAIL reset data: got addr=%h wdata=%h rdata=%h expected 0", core_addr, core_wdata, req_rdata); end
      checks++;
      if (f_ack !== '0 || f_busy !== 1'b0 || f_rdata !== '0 || f_core_addr !== '0) begin errors++;
         $display("FAIL reset dut4: got ack=%b busy=%b rdata=%h addr=%h expected 0", f_ack, f_busy, f_rdata, f_core_addr); end
      sys_rst = 1'b0;
      model_ptr = 0; exp_rdata = '0;
   endtask

   task automatic test_single_write();
      clear_cmds();
      ncmd[0] = 1; cw[0][0] = 1'b1; ca[0][0] = 22'h000010; cd[0][0] = 32'hDEADBEEF;
      run_round("single_write");
   endtask

   task automatic test_single_read();
      clear_cmds();
      ncmd[1] = 1; cw[1][0] = 1'b0; ca[1][0] = AW'($urandom);
      core_fixed_en = 1'b1; core_fixed = 32'h12345678;
      run_round("single_read");
      core_fixed_en = 1'b0;
   endtask

   task automatic test_alternate();
      clear_cmds();
      for (int i = 0; i < N; i++) begin
         ncmd[i] = 4;
         for (int j = 0; j < 4; j++) begin
            cw[i][j] = 1'b1; ca[i][j] = AW'($urandom); cd[i][j] = $urandom;
         end
      end
      run_round("alternate");
      checks++;
      if (obs.size() != 8) begin errors++;
         $display("FAIL alternate count: got %0d acks expected 8", obs.size()); end
      for (int k = 1; k < obs.size(); k++) begin
         checks++;
         if (obs[k] == obs[k-1]) begin errors++;
            $display("FAIL alternate repeat at %0d: got %0d twice expected a different requester", k, obs[k]); end
      end
   endtask

   task automatic test_latched_cmd();
      clear_cmds();
      ncmd[0] = 1; cw[0][0] = 1'b0; ca[0][0] = AW'($urandom); early[0][0] = 1'b1;
      run_round("latched_cmd");
   endtask

   task automatic test_reset_mid();
      logic [AW-1:0] a;
      a = AW'($urandom);
      @(negedge sys_clk);
      req_valid = 2'b01; req_we = 2'b00; req_addr[AW-1:0] = a;
      @(negedge sys_clk);
      req_valid = '0;
      @(negedge sys_clk);
      checks++;
      if (busy !== 1'b1) begin errors++;
         $display("FAIL reset_mid pre: got busy=%b expected 1", busy); end
      sys_rst = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0 || req_ack !== '0 || core_rden !== 1'b0 || req_rdata !== '0) begin errors++;
         $display("FAIL reset_mid async: got busy=%b ack=%b rden=%b rdata=%h expected 0", busy, req_ack, core_rden, req_rdata); end
      @(negedge sys_clk);
      checks++;
      if (busy !== 1'b0 || req_ack !== '0) begin errors++;
         $display("FAIL reset_mid held: got busy=%b ack=%b expected 0", busy, req_ack); end
      sys_rst = 1'b0;
      model_ptr = 0; exp_rdata = '0;
      clear_cmds();
      ncmd[0] = 1; ncmd[1] = 1;
      ca[0][0] = AW'($urandom); cd[0][0] = $urandom;
      ca[1][0] = AW'($urandom); cd[1][0] = $urandom;
      run_round("ptr_after_reset");
      checks++;
      if (obs.size() != 2 || obs[0] != 0) begin errors++;
         $display("FAIL ptr_after_reset first: got %0d acks first=%0d expected requester 0", obs.size(), (obs.size() > 0) ? obs[0] : -1); end
      clear_cmds();
      ncmd[1] = 1; cw[1][0] = 1'b0; ca[1][0] = AW'($urandom);
      run_round("req1_after_reset");
   endtask

   task automatic test_random();
      for (int r = 0; r < 8; r++) begin
         clear_cmds();
         for (int i = 0; i < N; i++) begin
            ncmd[i] = $urandom_range(1, MAXC);
            for (int j = 0; j < ncmd[i]; j++) begin
               cw[i][j] = 1'($urandom); ca[i][j] = AW'($urandom); cd[i][j] = $urandom;
               gap[i][j] = $urandom_range(0, 3); early[i][j] = 1'($urandom);
            end
         end
         run_round($sformatf("random%0d", r));
      end
   endtask

   task automatic test_four();
      logic [AW-1:0] a [N4];
      logic [DW-1:0] fexp;
      fexp = f_rdata;
      for (int i = 0; i < N4; i++) a[i] = AW'($urandom);
      for (int c = 0; c <= 13; c++) begin
         logic [N4-1:0] e_ack;
         logic e_rden;
         @(negedge sys_clk);
         e_ack = '0; e_rden = 0;
         for (int i = 0; i < N4; i++) begin
            if (c == 3*i + 1) e_rden = 1;
            if (c == 3*i + 2) begin e_ack[i] = 1'b1; fexp = core_val(a[i]); end
         end
         checks++;
         if (f_ack !== e_ack) begin errors++;
            $display("FAIL four ack c=%0d: got %b expected %b", c, f_ack, e_ack); end
         checks++;
         if (f_core_rden !== e_rden || f_core_wren !== 1'b0) begin errors++;
            $display("FAIL four strobes c=%0d: got rden=%b wren=%b expected %b 0", c, f_core_rden, f_core_wren, e_rden); end
         checks++;
         if (f_rdata !== fexp) begin errors++;
            $display("FAIL four rdata c=%0d: got %h expected %h", c, f_rdata, fexp); end
         for (int i = 0; i < N4; i++) begin
            f_valid[i] = (c < 3*i + 2);
            f_we[i] = 1'b0;
            f_addr[i*AW +: AW] = a[i];
            f_wdata[i*DW +: DW] = $urandom;
         end
      end
      f_valid = '0;
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_single_read();
      test_alternate();
      test_latched_cmd();
      test_reset_mid();
      test_random();
      test_four();
      repeat (2) @(negedge sys_clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
